// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, bout set when the bit needs to borrow.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, WIDTH+1 busy cycles per op.
// States: IDLE wait for start | RUN shift one bit per cycle | DONE one-cycle result pulse.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             B
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] xs_q, ys_q, res_q;
  logic             borrow_q;
  logic             b_out_q;
  logic [CNT_W-1:0] cnt_q;
  logic             bit_d, bit_bout;
  logic             last_bit;

  full_subtractor u_fs (
    .x    (xs_q[0]),
    .y    (ys_q[0]),
    .bin  (borrow_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  assign last_bit = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)    state_d = ST_RUN;
      ST_RUN:  if (last_bit) state_d = ST_DONE;
      ST_DONE:               state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_RUN:  busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // B has its own flop so the previous borrow-out stays visible while a new op runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xs_q     <= '0;
      ys_q     <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      b_out_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            xs_q     <= x;
            ys_q     <= y;
            borrow_q <= bin;
            cnt_q    <= '0;
          end
        end
        ST_RUN: begin
          xs_q     <= xs_q >> 1;
          ys_q     <= ys_q >> 1;
          res_q    <= {bit_d, res_q[WIDTH-1:1]};
          borrow_q <= bit_bout;
          cnt_q    <= cnt_q + 1'b1;
          if (last_bit) b_out_q <= bit_bout;
        end
        default: ;
      endcase
    end
  end

  assign D = res_q;
  assign B = b_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed plus randomized checks of serial_subtractor against an arithmetic reference.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] x, y;
  logic         bin;
  logic         busy, done;
  logic [W-1:0] D;
  logic         B;

  int checks   = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .B     (B)
  );

  always #5 clk = ~clk;

  // Reference: {borrow, difference} from plain integer subtraction.
  function automatic logic [W:0] ref_sub(input int xv, input int yv, input int bv);
    int diff;
    diff = xv - yv - bv;
    return {(diff < 0) ? 1'b1 : 1'b0, W'(diff & ((1 << W) - 1))};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op from IDLE and follow it through to the cycle after DONE.
  task automatic run_op(input string tag, input logic [W-1:0] xv, input logic [W-1:0] yv,
                        input logic bv);
    logic [W:0] e;
    int busy_cnt, done_cnt, done_at;
    e = ref_sub(int'(xv), int'(yv), int'(bv));
    x = xv; y = yv; bin = bv; start = 1'b1;
    tick();
    start = 1'b0;
    x = W'($urandom); y = W'($urandom); bin = 1'($urandom);
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int i = 0; i <= W + 1; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = i;
        chk({tag, ".D"}, 32'(D), 32'(e[W-1:0]));
        chk({tag, ".B"}, 32'(B), 32'(e[W]));
      end
      if (i <= W) tick();
    end
    chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(W + 1));
    chk({tag, ".done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, ".done_at"}, 32'(done_at), 32'(W));
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    chk({tag, ".hold_D"}, 32'(D), 32'(e[W-1:0]));
    chk({tag, ".hold_B"}, 32'(B), 32'(e[W]));
  endtask

  logic [W:0]   e1;
  logic [W:0]   exp_q[$];
  int           done_cnt, free_edge;
  int           done_sched[$];

  initial begin
    rst = 1'b1; start = 1'b0; x = '0; y = '0; bin = 1'b0;
    #12;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.D", 32'(D), 32'd0);
    chk("rst.B", 32'(B), 32'd0);
    @(negedge clk); rst = 1'b0;
    tick();
    chk("idle.busy", 32'(busy), 32'd0);

    run_op("v200_55", 8'd200, 8'd55, 1'b0);
    run_op("v5_10", 8'd5, 8'd10, 1'b0);
    run_op("v0_0_b1", 8'd0, 8'd0, 1'b1);
    run_op("v255_255", 8'd255, 8'd255, 1'b0);
    run_op("v255_0_b1", 8'd255, 8'd0, 1'b1);
    run_op("v0_255_b1", 8'd0, 8'd255, 1'b1);

    for (int k = 0; k < 12; k++)
      run_op("rand", W'($urandom), W'($urandom), 1'($urandom));

    // Second start three cycles after the first must be ignored.
    e1 = ref_sub(77, 200, 1);
    x = 8'd77; y = 8'd200; bin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    x = 8'd10; y = 8'd3; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < W + 6; i++) begin
      if (done) begin
        done_cnt++;
        chk("ignore.D", 32'(D), 32'(e1[W-1:0]));
        chk("ignore.B", 32'(B), 32'(e1[W]));
      end
      tick();
    end
    chk("ignore.done_count", 32'(done_cnt), 32'd1);
    chk("ignore.busy_end", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of RUN aborts the op.
    x = 8'd123; y = 8'd45; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("abort.busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.D", 32'(D), 32'd0);
    chk("abort.B", 32'(B), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < W + 3; i++) begin
      tick();
      if (done || busy) done_cnt++;
    end
    chk("abort.no_done", 32'(done_cnt), 32'd0);
    run_op("after_abort", 8'd90, 8'd91, 1'b0);

    // start held high for 30 cycles with operands changing every cycle.
    free_edge = 0;
    done_cnt  = 0;
    for (int e = 0; e < 40; e++) begin
      if (e < 30) begin
        x = W'($urandom); y = W'($urandom); bin = 1'($urandom); start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (e < 30 && e == free_edge) begin
        exp_q.push_back(ref_sub(int'(x), int'(y), int'(bin)));
        done_sched.push_back(e + W);
        free_edge = e + W + 2;
      end
      tick();
      if (done_sched.size() > 0 && done_sched[0] == e) begin
        void'(done_sched.pop_front());
        e1 = exp_q.pop_front();
        done_cnt++;
        chk("b2b.done", 32'(done), 32'd1);
        chk("b2b.D", 32'(D), 32'(e1[W-1:0]));
        chk("b2b.B", 32'(B), 32'(e1[W]));
      end else begin
        chk("b2b.no_done", 32'(done), 32'd0);
      end
    end
    chk("b2b.ops", 32'(done_cnt), 32'd3);
    chk("b2b.idle_end", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
